// File: rtl/featuremap_pad_writer.sv
// featuremap_pad_writer: streams one raster frame into the conv2d input FIFO,
// surrounding it with a one-word border of +0.0 so the FIFO receives the
// padded (WIDTH+2) x (HEIGHT+2) geometry the line buffers consume.
module featuremap_pad_writer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 112,
  parameter int unsigned HEIGHT     = 112
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*DATA_WIDTH-1:0] pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    fifo_full,
  output logic                    wrreq,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned PIX_W = 3 * DATA_WIDTH;
  localparam int unsigned COL_W = $clog2(WIDTH + 2);
  localparam int unsigned ROW_W = $clog2(HEIGHT + 2);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             border_c;

  // State and padded-raster position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Border decode of the current padded position
  always_comb begin
    border_c = (row_q == ROW_W'(0)) || (row_q == ROW_LAST) ||
               (col_q == COL_W'(0)) || (col_q == COL_LAST);
  end

  // Next state, raster advance and zero-latency FIFO write path
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    pix_ready  = 1'b0;
    wrreq      = 1'b0;
    data_out   = '0;
    busy       = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end

      ST_RUN: begin
        busy      = 1'b1;
        // Border words are generated locally and never wait on the source
        pix_ready = ~border_c & ~fifo_full;
        wrreq     = ~fifo_full & (border_c | pix_valid);
        data_out  = border_c ? PIX_W'(0) : pix_in;
        if (wrreq) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Directed bench for featuremap_pad_writer at WIDTH=4, HEIGHT=3 (30 padded words).
module tb_featuremap_pad_writer;

  localparam int DW = 32;
  localparam int PW = 3 * DW;
  localparam int NW = 30;

  logic          clk;
  logic          rst;
  logic          start;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          fifo_full;
  logic          wrreq;
  logic [PW-1:0] data_out;
  logic          busy;
  logic          frame_done;

  int checks;
  int failures;
  int frame_cnt;
  int wr_cnt;
  int cons_cnt;
  logic [PW-1:0] got [0:NW-1];

  featuremap_pad_writer #(
    .DATA_WIDTH(DW),
    .WIDTH     (4),
    .HEIGHT    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .fifo_full (fifo_full),
    .wrreq     (wrreq),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (frame_done) frame_cnt++;
    if (wrreq) wr_cnt++;
    if (pix_ready && pix_valid) cons_cnt++;
  end

  function automatic logic [PW-1:0] pix(input int k);
    return {32'(k), 32'(k + 100), 32'(k + 200)};
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one frame from IDLE and checks every RUN cycle against a position model
  task automatic run_frame(input string tag, input bit bp, input bit gaps, input int abort_after,
                           input bit start_in_run, input bit start_at_done, output int run_cycles);
    int p, k, cyc, stalls, r, c;
    bit brd, full, valid, exp_wr, exp_rdy;
    logic [PW-1:0] exp_data;
    p = 0; k = 0; cyc = 0; stalls = 0;
    start = 1'b1; fifo_full = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, PW'(busy), PW'(0));
    check({tag, "_idle_wrreq"}, PW'(wrreq), PW'(0));
    @(posedge clk); #1;
    while (p < NW && cyc < 200) begin
      full  = bp && (p == 0 || p == 8) && stalls < 3;
      valid = gaps ? (cyc % 2 == 0) : 1'b1;
      fifo_full = full; pix_valid = valid; pix_in = pix(k);
      start = start_in_run && (cyc == 5);
      if (abort_after > 0 && p == abort_after) begin
        rst = 1'b0;
        #1;
        check({tag, "_rst_wrreq"}, PW'(wrreq), PW'(0));
        check({tag, "_rst_ready"}, PW'(pix_ready), PW'(0));
        check({tag, "_rst_busy"}, PW'(busy), PW'(0));
        check({tag, "_rst_data"}, data_out, PW'(0));
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
        run_cycles = cyc;
        return;
      end
      r = p / 6; c = p % 6;
      brd      = (r == 0) || (r == 4) || (c == 0) || (c == 5);
      exp_wr   = !full && (brd || valid);
      exp_rdy  = !brd && !full;
      exp_data = brd ? PW'(0) : pix(k);
      @(negedge clk);
      check({tag, "_wrreq"}, PW'(wrreq), PW'(exp_wr));
      check({tag, "_ready"}, PW'(pix_ready), PW'(exp_rdy));
      check({tag, "_data"}, data_out, exp_data);
      check({tag, "_busy"}, PW'(busy), PW'(1));
      check({tag, "_done_early"}, PW'(frame_done), PW'(0));
      if (wrreq) got[p] = data_out;
      @(posedge clk); #1;
      if (full) stalls++;
      if (exp_wr) begin p++; stalls = 0; end
      if (exp_rdy && valid) k++;
      cyc++;
    end
    start = 1'b0;
    run_cycles = cyc;
    check({tag, "_words_written"}, PW'(p), PW'(NW));
    start = start_at_done; fifo_full = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    check({tag, "_frame_done"}, PW'(frame_done), PW'(1));
    check({tag, "_done_busy"}, PW'(busy), PW'(0));
    check({tag, "_done_wrreq"}, PW'(wrreq), PW'(0));
    check({tag, "_done_ready"}, PW'(pix_ready), PW'(0));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int cyc_n, f0, w0, c0;
    checks = 0; failures = 0; frame_cnt = 0; wr_cnt = 0; cons_cnt = 0;
    rst = 1'b0; start = 1'b0; fifo_full = 1'b0;
    pix_valid = 1'b1; pix_in = pix(7);

    // Reset state with a live-looking source on the inputs
    #2;
    check("reset_wrreq", PW'(wrreq), PW'(0));
    check("reset_ready", PW'(pix_ready), PW'(0));
    check("reset_busy", PW'(busy), PW'(0));
    check("reset_done", PW'(frame_done), PW'(0));
    check("reset_data", data_out, PW'(0));
    @(posedge clk); #1;
    rst = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;

    // Continuous stream
    f0 = frame_cnt; w0 = wr_cnt;
    run_frame("s1", 1'b0, 1'b0, 0, 1'b0, 1'b0, cyc_n);
    check("s1_cycles", PW'(cyc_n), PW'(30));
    check("s1_wr_count", PW'(wr_cnt - w0), PW'(30));
    check("s1_frames", PW'(frame_cnt - f0), PW'(1));
    check("s1_word0", got[0], PW'(0));
    check("s1_word5", got[5], PW'(0));
    check("s1_word7", got[7], {32'd0, 32'd100, 32'd200});
    check("s1_word22", got[22], {32'd11, 32'd111, 32'd211});
    check("s1_word24", got[24], PW'(0));
    check("s1_word29", got[29], PW'(0));

    // Back-pressure at a border word and an interior word
    run_frame("s2", 1'b1, 1'b0, 0, 1'b0, 1'b0, cyc_n);
    check("s2_cycles", PW'(cyc_n), PW'(36));
    check("s2_word7", got[7], {32'd0, 32'd100, 32'd200});
    check("s2_word8", got[8], {32'd1, 32'd101, 32'd201});

    // Upstream gaps on alternate cycles
    c0 = cons_cnt;
    run_frame("s3", 1'b0, 1'b1, 0, 1'b0, 1'b0, cyc_n);
    check("s3_cycles", PW'(cyc_n), PW'(42));
    check("s3_consumed", PW'(cons_cnt - c0), PW'(12));
    check("s3_word22", got[22], {32'd11, 32'd111, 32'd211});

    // Reset mid-frame, then a clean frame
    f0 = frame_cnt;
    run_frame("s4a", 1'b0, 1'b0, 10, 1'b0, 1'b0, cyc_n);
    check("s4_abort_cycle", PW'(cyc_n), PW'(10));
    check("s4_no_done", PW'(frame_cnt - f0), PW'(0));
    w0 = wr_cnt;
    run_frame("s4b", 1'b0, 1'b0, 0, 1'b0, 1'b0, cyc_n);
    check("s4_cycles", PW'(cyc_n), PW'(30));
    check("s4_wr_count", PW'(wr_cnt - w0), PW'(30));
    check("s4_word0", got[0], PW'(0));

    // Start ignored in RUN and on the frame_done cycle
    f0 = frame_cnt;
    run_frame("s5a", 1'b0, 1'b0, 0, 1'b1, 1'b1, cyc_n);
    check("s5_cycles", PW'(cyc_n), PW'(30));
    check("s5_frames1", PW'(frame_cnt - f0), PW'(1));
    run_frame("s5b", 1'b0, 1'b0, 0, 1'b0, 1'b0, cyc_n);
    check("s5_frames2", PW'(frame_cnt - f0), PW'(2));
    check("s5_f2_word6", got[6], PW'(0));
    check("s5_f2_word7", got[7], {32'd0, 32'd100, 32'd200});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
